// File: rtl/alu_share_ctrl_if.sv
// Handshake bundle for alu_share_ctrl: two requester request/response channels
// plus the shared-ALU operand/result wires and the BUSY status.
interface alu_share_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OPRN_WIDTH = 6
);
    logic                  REQ0_VALID;
    logic                  REQ0_READY;
    logic [DATA_WIDTH-1:0] REQ0_OP1;
    logic [DATA_WIDTH-1:0] REQ0_OP2;
    logic [OPRN_WIDTH-1:0] REQ0_OPRN;
    logic                  RSP0_VALID;
    logic                  RSP0_READY;
    logic [DATA_WIDTH-1:0] RSP0_DATA;
    logic                  RSP0_ZERO;

    logic                  REQ1_VALID;
    logic                  REQ1_READY;
    logic [DATA_WIDTH-1:0] REQ1_OP1;
    logic [DATA_WIDTH-1:0] REQ1_OP2;
    logic [OPRN_WIDTH-1:0] REQ1_OPRN;
    logic                  RSP1_VALID;
    logic                  RSP1_READY;
    logic [DATA_WIDTH-1:0] RSP1_DATA;
    logic                  RSP1_ZERO;

    logic [DATA_WIDTH-1:0] ALU_OP1;
    logic [DATA_WIDTH-1:0] ALU_OP2;
    logic [OPRN_WIDTH-1:0] ALU_OPRN;
    logic [DATA_WIDTH-1:0] ALU_OUT;
    logic                  ALU_ZERO;
    logic                  BUSY;

    modport slave (
        input  REQ0_VALID, REQ0_OP1, REQ0_OP2, REQ0_OPRN, RSP0_READY,
        input  REQ1_VALID, REQ1_OP1, REQ1_OP2, REQ1_OPRN, RSP1_READY,
        input  ALU_OUT, ALU_ZERO,
        output REQ0_READY, RSP0_VALID, RSP0_DATA, RSP0_ZERO,
        output REQ1_READY, RSP1_VALID, RSP1_DATA, RSP1_ZERO,
        output ALU_OP1, ALU_OP2, ALU_OPRN, BUSY
    );

    modport master (
        output REQ0_VALID, REQ0_OP1, REQ0_OP2, REQ0_OPRN, RSP0_READY,
        output REQ1_VALID, REQ1_OP1, REQ1_OP2, REQ1_OPRN, RSP1_READY,
        output ALU_OUT, ALU_ZERO,
        input  REQ0_READY, RSP0_VALID, RSP0_DATA, RSP0_ZERO,
        input  REQ1_READY, RSP1_VALID, RSP1_DATA, RSP1_ZERO,
        input  ALU_OP1, ALU_OP2, ALU_OPRN, BUSY
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter/sequencer in front of a shared combinational ALU.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OPRN_WIDTH  = 6,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    alu_share_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       owner;
    logic [3:0] count;
    logic       prio0;
    logic       grant0;
    logic       grant1;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign prio0 = 1'b1;
`else
    logic rr_ptr;
    assign prio0 = ~rr_ptr;
`endif

    assign grant0 = bus.REQ0_VALID && (!bus.REQ1_VALID || prio0);
    assign grant1 = bus.REQ1_VALID && !grant0;

    assign bus.REQ0_READY = (state == IDLE) && grant0;
    assign bus.REQ1_READY = (state == IDLE) && grant1;
    assign bus.BUSY       = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            owner          <= 1'b0;
            count          <= '0;
            bus.ALU_OP1    <= '0;
            bus.ALU_OP2    <= '0;
            bus.ALU_OPRN   <= '0;
            bus.RSP0_VALID <= 1'b0;
            bus.RSP0_DATA  <= '0;
            bus.RSP0_ZERO  <= 1'b0;
            bus.RSP1_VALID <= 1'b0;
            bus.RSP1_DATA  <= '0;
            bus.RSP1_ZERO  <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            rr_ptr         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        bus.ALU_OP1  <= grant1 ? bus.REQ1_OP1  : bus.REQ0_OP1;
                        bus.ALU_OP2  <= grant1 ? bus.REQ1_OP2  : bus.REQ0_OP2;
                        bus.ALU_OPRN <= grant1 ? bus.REQ1_OPRN : bus.REQ0_OPRN;
                        owner        <= grant1;
                        // Counting down from EXEC_CYCLES (not -1) adds the operand-register
                        // cycle, so the result is valid EXEC_CYCLES+1 edges after accept.
                        count        <= 4'(EXEC_CYCLES);
                        state        <= EXEC;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        rr_ptr       <= ~grant1;
`endif
                    end else begin
                        bus.ALU_OPRN <= '0;
                    end
                end
                EXEC: begin
                    if (count == '0) begin
                        if (owner) begin
                            bus.RSP1_DATA  <= bus.ALU_OUT;
                            bus.RSP1_ZERO  <= bus.ALU_ZERO;
                            bus.RSP1_VALID <= 1'b1;
                        end else begin
                            bus.RSP0_DATA  <= bus.ALU_OUT;
                            bus.RSP0_ZERO  <= bus.ALU_ZERO;
                            bus.RSP0_VALID <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (owner ? bus.RSP1_READY : bus.RSP0_READY) begin
                        bus.RSP0_VALID <= 1'b0;
                        bus.RSP1_VALID <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a small reference ALU.
module tb_alu_share_ctrl;
    logic CLK;
    logic RST;
    int   n_assert;
    int   n_fail;

    alu_share_ctrl_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) bus ();

    alu_share_ctrl #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .EXEC_CYCLES(1)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU: 1 add, 2 sub, 3 mul, 7 or; anything else yields 0.
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.ALU_OPRN)
            6'h01: alu_res = bus.ALU_OP1 + bus.ALU_OP2;
            6'h02: alu_res = bus.ALU_OP1 - bus.ALU_OP2;
            6'h03: alu_res = bus.ALU_OP1 * bus.ALU_OP2;
            6'h07: alu_res = bus.ALU_OP1 | bus.ALU_OP2;
            default: alu_res = '0;
        endcase
        bus.ALU_OUT  = alu_res;
        bus.ALU_ZERO = (alu_res == '0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_g1;
        logic [31:0] exp_data;
        n_assert = 0;
        n_fail   = 0;
        RST = 1'b1;
        bus.REQ0_VALID = 1'b0; bus.REQ0_OP1 = '0; bus.REQ0_OP2 = '0; bus.REQ0_OPRN = '0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_OP1 = '0; bus.REQ1_OP2 = '0; bus.REQ1_OPRN = '0;
        bus.RSP0_READY = 1'b0; bus.RSP1_READY = 1'b0;
        tick(); tick();
        RST = 1'b0;

        check("rst_ready0", 32'(bus.REQ0_READY), 0);
        check("rst_ready1", 32'(bus.REQ1_READY), 0);
        check("rst_rsp0_valid", 32'(bus.RSP0_VALID), 0);
        check("rst_rsp1_valid", 32'(bus.RSP1_VALID), 0);
        check("rst_rsp0_data", bus.RSP0_DATA, 0);
        check("rst_alu_oprn", 32'(bus.ALU_OPRN), 0);
        check("rst_busy", 32'(bus.BUSY), 0);

        // Test 1: requester 0 add
        bus.REQ0_VALID = 1'b1; bus.REQ0_OP1 = 5; bus.REQ0_OP2 = 7; bus.REQ0_OPRN = 6'h01;
        #1;
        check("t1_ready0", 32'(bus.REQ0_READY), 1);
        check("t1_ready1", 32'(bus.REQ1_READY), 0);
        tick();
        bus.REQ0_VALID = 1'b0;
        check("t1_busy", 32'(bus.BUSY), 1);
        check("t1_alu_op1", bus.ALU_OP1, 5);
        check("t1_alu_oprn", 32'(bus.ALU_OPRN), 1);
        check("t1_ready0_exec", 32'(bus.REQ0_READY), 0);
        check("t1_valid_n1", 32'(bus.RSP0_VALID), 0);
        tick();
        check("t1_valid_n2", 32'(bus.RSP0_VALID), 0);
        tick();
        check("t1_valid", 32'(bus.RSP0_VALID), 1);
        check("t1_data", bus.RSP0_DATA, 12);
        check("t1_zero", 32'(bus.RSP0_ZERO), 0);
        check("t1_rsp1_valid", 32'(bus.RSP1_VALID), 0);
        bus.RSP0_READY = 1'b1;
        tick();
        bus.RSP0_READY = 1'b0;
        check("t1_valid_drop", 32'(bus.RSP0_VALID), 0);
        check("t1_busy_idle", 32'(bus.BUSY), 0);
        tick();
        check("t1_oprn_idle", 32'(bus.ALU_OPRN), 0);

        // Test 2: requester 1 subtract to zero
        bus.REQ1_VALID = 1'b1; bus.REQ1_OP1 = 9; bus.REQ1_OP2 = 9; bus.REQ1_OPRN = 6'h02;
        #1;
        check("t2_ready1", 32'(bus.REQ1_READY), 1);
        check("t2_ready0", 32'(bus.REQ0_READY), 0);
        tick();
        bus.REQ1_VALID = 1'b0;
        tick(); tick();
        check("t2_valid1", 32'(bus.RSP1_VALID), 1);
        check("t2_data1", bus.RSP1_DATA, 0);
        check("t2_zero1", 32'(bus.RSP1_ZERO), 1);
        check("t2_valid0", 32'(bus.RSP0_VALID), 0);
        bus.RSP1_READY = 1'b1;
        tick();
        bus.RSP1_READY = 1'b0;
        check("t2_valid_drop", 32'(bus.RSP1_VALID), 0);

        // Test 3: both requesters continuously valid after reset
        RST = 1'b1; tick(); RST = 1'b0;
        bus.REQ0_VALID = 1'b1; bus.REQ0_OP1 = 32'h0F;  bus.REQ0_OP2 = 32'hF0; bus.REQ0_OPRN = 6'h07;
        bus.REQ1_VALID = 1'b1; bus.REQ1_OP1 = 32'h100; bus.REQ1_OP2 = 32'h01; bus.REQ1_OPRN = 6'h07;
        bus.RSP0_READY = 1'b1; bus.RSP1_READY = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            exp_g1 = 1'b0;
`else
            exp_g1 = (i % 2 == 1);
`endif
            exp_data = exp_g1 ? 32'h101 : 32'hFF;
            check($sformatf("t3_grant0_%0d", i), 32'(bus.REQ0_READY), 32'(!exp_g1));
            check($sformatf("t3_grant1_%0d", i), 32'(bus.REQ1_READY), 32'(exp_g1));
            tick(); tick(); tick();
            check($sformatf("t3_valid_%0d", i),
                  32'(exp_g1 ? bus.RSP1_VALID : bus.RSP0_VALID), 1);
            check($sformatf("t3_other_%0d", i),
                  32'(exp_g1 ? bus.RSP0_VALID : bus.RSP1_VALID), 0);
            check($sformatf("t3_data_%0d", i), exp_g1 ? bus.RSP1_DATA : bus.RSP0_DATA, exp_data);
            check($sformatf("t3_nogrant_%0d", i), 32'(bus.REQ0_READY | bus.REQ1_READY), 0);
            tick();
        end
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        bus.RSP0_READY = 1'b0; bus.RSP1_READY = 1'b0;
        tick();

        // Test 4: multiply with response back-pressure
        bus.REQ0_VALID = 1'b1; bus.REQ0_OP1 = 3; bus.REQ0_OP2 = 4; bus.REQ0_OPRN = 6'h03;
        tick();
        bus.REQ0_VALID = 1'b0;
        tick(); tick();
        bus.REQ1_VALID = 1'b1; bus.REQ1_OP1 = 1; bus.REQ1_OP2 = 1; bus.REQ1_OPRN = 6'h01;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4_valid_%0d", i), 32'(bus.RSP0_VALID), 1);
            check($sformatf("t4_data_%0d", i), bus.RSP0_DATA, 12);
            check($sformatf("t4_nogrant_%0d", i), 32'(bus.REQ1_READY), 0);
            tick();
        end
        check("t4_busy_held", 32'(bus.BUSY), 1);
        bus.RSP0_READY = 1'b1;
        tick();
        bus.RSP0_READY = 1'b0;
        bus.REQ1_VALID = 1'b0;
        check("t4_valid_drop", 32'(bus.RSP0_VALID), 0);
        tick();
        check("t4_no_issue", 32'(bus.BUSY), 0);

        // Test 5: reset while executing discards the op
        bus.REQ1_VALID = 1'b1; bus.REQ1_OP1 = 1; bus.REQ1_OP2 = 1; bus.REQ1_OPRN = 6'h01;
        bus.RSP1_READY = 1'b1;
        tick();
        bus.REQ1_VALID = 1'b0;
        check("t5_in_exec", 32'(bus.BUSY), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_busy", 32'(bus.BUSY), 0);
        check("t5_alu_op1", bus.ALU_OP1, 0);
        check("t5_alu_oprn", 32'(bus.ALU_OPRN), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_no_rsp_%0d", i), 32'(bus.RSP1_VALID), 0);
        end
        check("t5_data", bus.RSP1_DATA, 0);
        bus.RSP1_READY = 1'b0;

        // Undefined op code: result 0, ZERO set
        bus.REQ0_VALID = 1'b1; bus.REQ0_OP1 = 32'h55; bus.REQ0_OP2 = 32'hAA; bus.REQ0_OPRN = 6'h3F;
        tick();
        bus.REQ0_VALID = 1'b0;
        tick(); tick();
        check("undef_valid", 32'(bus.RSP0_VALID), 1);
        check("undef_data", bus.RSP0_DATA, 0);
        check("undef_zero", 32'(bus.RSP0_ZERO), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
